// File: rtl/vend_ctrl_n.sv
// rtl/vend_ctrl_n.sv - vending machine controller with credit, stock and greedy change
//
// Purpose: accepts coins into a nickel-denominated credit, vends a selected
// product when funded and in stock, shows the price on an underfunded select,
// and pays change back one coin per cycle, largest denomination first.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-high
//   sel          - one-hot product select, level sampled each cycle
//   coin         - one-hot coin {five,dollar,fifty,quarter,dime,nickel}
//   cancel       - refund the current credit
//   restock      - refill slot restockSlot to full stock
//   restockSlot  - slot index for restock
//   gLED/rLED    - per slot: affordable / sold out
//   dLED         - per slot: dispense pulse
//   value        - displayed amount in nickels (credit, or price while showPrice)
//   showPrice    - value is showing a price
//   coinReject   - one-cycle pulse for a refused coin
//   changeValid  - one-cycle pulse, changeCoin holds the coin code (0=nickel..5=five)
//   busy         - high while vending or paying change
module vend_ctrl_n #(
  parameter int SLOTS    = 9,
  parameter int STOCK_W  = 4,
  parameter int CREDIT_W = 8,
  parameter logic [SLOTS*CREDIT_W-1:0] PRICES = {SLOTS{CREDIT_W'(5)}},
  parameter int HOLD     = 4,
  localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SLOTS-1:0]    sel,
  input  logic [5:0]          coin,
  input  logic                cancel,
  input  logic                restock,
  input  logic [IDX_W-1:0]    restockSlot,
  output logic [SLOTS-1:0]    gLED,
  output logic [SLOTS-1:0]    rLED,
  output logic [SLOTS-1:0]    dLED,
  output logic [CREDIT_W-1:0] value,
  output logic                showPrice,
  output logic                coinReject,
  output logic                changeValid,
  output logic [2:0]          changeCoin,
  output logic                busy
);

  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  // Extended width so credit + largest coin weight cannot wrap before the limit check.
  localparam int EW = CREDIT_W + 8;
  localparam logic [EW-1:0] CREDIT_MAX = EW'((1 << CREDIT_W) - 1);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [SLOTS];
  logic [STOCK_W-1:0]  stock_d [SLOTS];
  logic [HW-1:0]       hold_q, hold_d;
  logic [CREDIT_W-1:0] shown_q, shown_d;
  logic [SLOTS-1:0]    gled_q, gled_d, rled_q, rled_d, dled_q, dled_d;
  logic [CREDIT_W-1:0] value_q, value_d;
  logic                show_q, show_d, reject_q, reject_d, chg_valid_q, chg_valid_d, busy_q, busy_d;
  logic [2:0]          chg_coin_q, chg_coin_d;

  logic                sel_one, coin_one, coin_ok;
  logic [IDX_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] sel_price;
  logic [7:0]          coin_w, chg_w;
  logic [EW-1:0]       coin_sum, cr_ext;

  function automatic logic [7:0] coin_weight(input logic [5:0] c);
    case (c)
      6'b000001: return 8'd1;
      6'b000010: return 8'd2;
      6'b000100: return 8'd5;
      6'b001000: return 8'd10;
      6'b010000: return 8'd20;
      6'b100000: return 8'd100;
      default:   return 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    stock_d     = stock_q;
    hold_d      = hold_q;
    shown_d     = shown_q;
    dled_d      = '0;
    chg_valid_d = 1'b0;
    chg_coin_d  = 3'd0;
    coin_ok     = 1'b0;
    chg_w       = 8'd0;

    sel_one  = (sel != '0) && ((sel & (sel - SLOTS'(1))) == '0);
    coin_one = (coin != '0) && ((coin & (coin - 6'd1)) == '0);
    sel_idx  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
    sel_price = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
    coin_w    = coin_weight(coin);
    cr_ext    = {8'b0, credit_q};
    coin_sum  = cr_ext + {{CREDIT_W{1'b0}}, coin_w};

    if (hold_q != '0) hold_d = hold_q - HW'(1);

    case (state_q)
      IDLE: begin
        if (cancel && credit_q != '0) begin
          state_d = CHANGE;
          hold_d  = '0;
        end else if (sel_one && stock_q[sel_idx] != '0) begin
          if (credit_q >= sel_price) begin
            state_d          = VEND;
            dled_d[sel_idx]  = 1'b1;
            stock_d[sel_idx] = stock_q[sel_idx] - STOCK_W'(1);
            credit_d         = credit_q - sel_price;
            hold_d           = '0;
          end else begin
            // Underfunded: show the price; a repeated select restarts the hold.
            hold_d  = HW'(HOLD);
            shown_d = sel_price;
          end
        end else if (restock && int'(restockSlot) < SLOTS) begin
          stock_d[restockSlot] = '1;
        end else if (coin_one && coin_sum <= CREDIT_MAX) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          coin_ok  = 1'b1;
        end
      end
      VEND: state_d = (credit_q != '0) ? CHANGE : IDLE;
      CHANGE: begin
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          if      (cr_ext >= EW'(100)) begin chg_coin_d = 3'd5; chg_w = 8'd100; end
          else if (cr_ext >= EW'(20))  begin chg_coin_d = 3'd4; chg_w = 8'd20;  end
          else if (cr_ext >= EW'(10))  begin chg_coin_d = 3'd3; chg_w = 8'd10;  end
          else if (cr_ext >= EW'(5))   begin chg_coin_d = 3'd2; chg_w = 8'd5;   end
          else if (cr_ext >= EW'(2))   begin chg_coin_d = 3'd1; chg_w = 8'd2;   end
          else                         begin chg_coin_d = 3'd0; chg_w = 8'd1;   end
          chg_valid_d = 1'b1;
          credit_d    = credit_q - CREDIT_W'(chg_w);
          if (credit_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    reject_d = (coin != '0) && !coin_ok;
    show_d   = (hold_d != '0);
    value_d  = show_d ? shown_d : credit_d;
    busy_d   = (state_d != IDLE);

    // LEDs follow registered credit/stock, so they trail a change by one cycle.
    for (int i = 0; i < SLOTS; i++) begin
      rled_d[i] = (stock_q[i] == '0);
      gled_d[i] = (stock_q[i] != '0) && (credit_q >= PRICES[i*CREDIT_W +: CREDIT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      for (int i = 0; i < SLOTS; i++) stock_q[i] <= '1;
      hold_q      <= '0;
      shown_q     <= '0;
      gled_q      <= '0;
      rled_q      <= '0;
      dled_q      <= '0;
      value_q     <= '0;
      show_q      <= 1'b0;
      reject_q    <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_coin_q  <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      stock_q     <= stock_d;
      hold_q      <= hold_d;
      shown_q     <= shown_d;
      gled_q      <= gled_d;
      rled_q      <= rled_d;
      dled_q      <= dled_d;
      value_q     <= value_d;
      show_q      <= show_d;
      reject_q    <= reject_d;
      chg_valid_q <= chg_valid_d;
      chg_coin_q  <= chg_coin_d;
      busy_q      <= busy_d;
    end
  end

  assign gLED        = gled_q;
  assign rLED        = rled_q;
  assign dLED        = dled_q;
  assign value       = value_q;
  assign showPrice   = show_q;
  assign coinReject  = reject_q;
  assign changeValid = chg_valid_q;
  assign changeCoin  = chg_coin_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_n.sv
// tb/tb_vend_ctrl_n.sv - scoreboard bench for vend_ctrl_n with directed vectors
module tb_vend_ctrl_n;

  localparam int HOLD = 4;
  localparam logic [5:0] NICKEL  = 6'b000001;
  localparam logic [5:0] DIME    = 6'b000010;
  localparam logic [5:0] QUARTER = 6'b000100;
  localparam logic [5:0] DOLLAR  = 6'b010000;
  localparam logic [5:0] FIVE    = 6'b100000;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] sel;
  logic [5:0] coin;
  logic       cancel, restock;
  logic [3:0] restockSlot;
  logic [8:0] gLED, rLED, dLED;
  logic [7:0] value;
  logic       showPrice, coinReject, changeValid, busy;
  logic [2:0] changeCoin;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_disp [$];
  logic [2:0] exp_chg  [$];
  logic       exp_rej  [$];
  logic [8:0] mon_d;
  logic [2:0] mon_c;
  int         busy_cnt;

  always #5 clk = ~clk;

  vend_ctrl_n dut (
    .clk(clk), .reset(reset), .sel(sel), .coin(coin), .cancel(cancel),
    .restock(restock), .restockSlot(restockSlot), .gLED(gLED), .rLED(rLED),
    .dLED(dLED), .value(value), .showPrice(showPrice), .coinReject(coinReject),
    .changeValid(changeValid), .changeCoin(changeCoin), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sel = '0; coin = '0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic put_coin(input logic [5:0] c);
    coin = c;
    step();
  endtask

  // Monitor: pops expected pulses whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (dLED != '0) begin
        checks++;
        if (exp_disp.size() == 0) begin
          errors++;
          $display("FAIL dispense: got dLED=%b, none expected", dLED);
        end else begin
          mon_d = exp_disp.pop_front();
          if (dLED !== mon_d) begin
            errors++;
            $display("FAIL dispense: got dLED=%b expected %b", dLED, mon_d);
          end
        end
      end
      if (changeValid === 1'b1) begin
        checks++;
        if (exp_chg.size() == 0) begin
          errors++;
          $display("FAIL change: got coin %0d, none expected", changeCoin);
        end else begin
          mon_c = exp_chg.pop_front();
          if (changeCoin !== mon_c) begin
            errors++;
            $display("FAIL change: got coin %0d expected %0d", changeCoin, mon_c);
          end
        end
      end
      if (coinReject === 1'b1) begin
        checks++;
        if (exp_rej.size() == 0) begin
          errors++;
          $display("FAIL reject: got coinReject, none expected");
        end else begin
          void'(exp_rej.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = '0; coin = '0; cancel = 1'b0; restock = 1'b0; restockSlot = '0;
    step(); step();
    chk("rst_value", value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_show", showPrice, 0);
    chk("rst_gled", gLED, 0);
    chk("rst_rled", rLED, 0);
    chk("rst_dled", dLED, 0);
    reset = 1'b0;
    step();
    chk("idle_rled", rLED, 0);
    chk("idle_gled", gLED, 0);

    // Dollar, buy slot 0: 15 nickels back as fifty then quarter.
    put_coin(DOLLAR);
    chk("dollar_value", value, 20);
    step();
    chk("dollar_gled", gLED, 9'h1FF);
    sel = 9'b000000001;
    exp_disp.push_back(9'b000000001);
    exp_chg.push_back(3'd3);
    exp_chg.push_back(3'd2);
    step();
    chk("vend_busy", busy, 1);
    chk("vend_value", value, 15);
    step(); step(); step(); step();
    chk("vend_done_busy", busy, 0);
    chk("vend_done_value", value, 0);

    // Underfunded select shows price for HOLD cycles.
    sel = 9'b000000001;
    step();
    for (int k = 0; k < HOLD; k++) begin
      chk("hold_show", showPrice, 1);
      chk("hold_value", value, 5);
      step();
    end
    chk("hold_end_show", showPrice, 0);
    chk("hold_end_value", value, 0);
    chk("hold_rled", rLED, 0);

    // Empty slot 2, then sold-out select, then restock.
    for (int n = 0; n < 15; n++) begin
      put_coin(QUARTER);
      sel = 9'b000000100;
      exp_disp.push_back(9'b000000100);
      step(); step();
    end
    step();
    chk("soldout_rled", rLED, 9'b000000100);
    put_coin(QUARTER);
    sel = 9'b000000100;
    step(); step();
    chk("soldout_busy", busy, 0);
    chk("soldout_value", value, 5);
    restock = 1'b1; restockSlot = 4'd2;
    step(); step();
    chk("restock_rled", rLED, 0);
    chk("restock_gled", gLED, 9'h1FF);
    cancel = 1'b1;
    exp_chg.push_back(3'd2);
    step(); step(); step();
    chk("refund_value", value, 0);

    // Overflow, multi-bit coin, and coin during CHANGE.
    put_coin(FIVE);
    put_coin(FIVE);
    chk("credit200", value, 200);
    exp_rej.push_back(1'b1);
    put_coin(FIVE);
    exp_rej.push_back(1'b1);
    put_coin(6'b000011);
    step();
    chk("overflow_value", value, 200);
    cancel = 1'b1;
    exp_chg.push_back(3'd5);
    exp_chg.push_back(3'd5);
    step();
    exp_rej.push_back(1'b1);
    put_coin(NICKEL);
    step(); step();
    chk("chg200_value", value, 0);

    // Nickel, dime, quarter, cancel: quarter, dime, nickel back.
    put_coin(NICKEL);
    put_coin(DIME);
    put_coin(QUARTER);
    chk("credit8", value, 8);
    cancel = 1'b1;
    exp_chg.push_back(3'd2);
    exp_chg.push_back(3'd1);
    exp_chg.push_back(3'd0);
    step();
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy === 1'b1) busy_cnt++;
      step();
    end
    chk("cancel_busy_cycles", busy_cnt, 3);
    chk("cancel_value", value, 0);

    // Reset on second CHANGE cycle aborts the refund.
    put_coin(NICKEL);
    put_coin(DIME);
    put_coin(QUARTER);
    cancel = 1'b1;
    exp_chg.push_back(3'd2);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step(); step();
    chk("abort_value", value, 0);
    chk("abort_busy", busy, 0);
    chk("abort_chg", changeValid, 0);
    chk("abort_show", showPrice, 0);

    chk("drain_disp", exp_disp.size(), 0);
    chk("drain_chg", exp_chg.size(), 0);
    chk("drain_rej", exp_rej.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
